// File: rtl/dm_dump_ctrl.sv
// Streams a window of data memory out through the UART transmitter as a framed byte stream:
// sync byte, each word as hi/lo bytes, then an XOR checksum of the payload bytes.
module dm_dump_ctrl #(
  parameter int          ADDR_W     = 12,
  parameter int          RD_LATENCY = 1,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              rd_dm,
  input  logic [15:0]       dm_data,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    IDLE, SYNC, WAIT_SYNC, RD, RD_WAIT, SEND_HI, WAIT_HI,
    SEND_LO, WAIT_LO, SUM, WAIT_SUM, FIN
  } state_t;

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [1:0]      LAT_LAST  = 2'(RD_LATENCY - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W:0]   remaining_reg, remaining_next;
  logic [15:0]       word_reg, word_next;
  logic [7:0]        checksum_reg, checksum_next;
  logic [1:0]        lat_reg, lat_next;
  logic [ADDR_W-1:0] dm_addr_reg, dm_addr_next;
  logic              rd_dm_reg, rd_dm_next;
  logic              tx_start_reg, tx_start_next;
  logic [7:0]        tx_data_reg, tx_data_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  assign dm_addr  = dm_addr_reg;
  assign rd_dm    = rd_dm_reg;
  assign tx_start = tx_start_reg;
  assign tx_data  = tx_data_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      word_reg      <= '0;
      checksum_reg  <= '0;
      lat_reg       <= '0;
      dm_addr_reg   <= '0;
      rd_dm_reg     <= 1'b0;
      tx_start_reg  <= 1'b0;
      tx_data_reg   <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      word_reg      <= word_next;
      checksum_reg  <= checksum_next;
      lat_reg       <= lat_next;
      dm_addr_reg   <= dm_addr_next;
      rd_dm_reg     <= rd_dm_next;
      tx_start_reg  <= tx_start_next;
      tx_data_reg   <= tx_data_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  // Outputs are decoded from the state being entered, so each registered strobe
  // is high exactly while the FSM sits in the state that owns it.
  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    word_next      = word_reg;
    checksum_next  = checksum_reg;
    lat_next       = lat_reg;
    dm_addr_next   = dm_addr_reg;
    rd_dm_next     = 1'b0;
    tx_start_next  = 1'b0;
    tx_data_next   = tx_data_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          addr_next      = base_addr;
          remaining_next = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
          checksum_next  = '0;
          busy_next      = 1'b1;
          state_next     = SYNC;
          tx_start_next  = 1'b1;
          tx_data_next   = SYNC_BYTE;
        end
      end
      SYNC: state_next = WAIT_SYNC;
      WAIT_SYNC: begin
        if (tx_done) begin
          if (remaining_reg == '0) begin
            state_next    = SUM;
            tx_start_next = 1'b1;
            tx_data_next  = checksum_reg;
          end else begin
            state_next   = RD;
            rd_dm_next   = 1'b1;
            dm_addr_next = addr_reg;
            lat_next     = '0;
          end
        end
      end
      RD: state_next = RD_WAIT;
      RD_WAIT: begin
        if (lat_reg == LAT_LAST) begin
          word_next     = dm_data;
          state_next    = SEND_HI;
          tx_start_next = 1'b1;
          tx_data_next  = dm_data[15:8];
          checksum_next = checksum_reg ^ dm_data[15:8];
        end else begin
          lat_next = lat_reg + 2'd1;
        end
      end
      SEND_HI: state_next = WAIT_HI;
      WAIT_HI: begin
        if (tx_done) begin
          state_next    = SEND_LO;
          tx_start_next = 1'b1;
          tx_data_next  = word_reg[7:0];
          checksum_next = checksum_reg ^ word_reg[7:0];
        end
      end
      SEND_LO: state_next = WAIT_LO;
      WAIT_LO: begin
        if (tx_done) begin
          addr_next      = addr_reg + ADDR_W'(1);
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == (ADDR_W+1)'(1)) begin
            state_next    = SUM;
            tx_start_next = 1'b1;
            tx_data_next  = checksum_reg;
          end else begin
            state_next   = RD;
            rd_dm_next   = 1'b1;
            dm_addr_next = addr_next;
            lat_next     = '0;
          end
        end
      end
      SUM: state_next = WAIT_SUM;
      WAIT_SUM: begin
        if (tx_done) begin
          state_next = FIN;
          done_next  = 1'b1;
          busy_next  = 1'b0;
        end
      end
      FIN: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dm_dump_ctrl.sv
// Directed bench for dm_dump_ctrl: a latency-1 and a latency-3 instance, each with a
// memory model and a UART responder that logs every transmitted byte and read address.
module tb_dm_dump_ctrl;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          start_a = 1'b0, start_b = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   count = '0;
  logic [AW-1:0] dm_addr_a, dm_addr_b;
  logic          rd_dm_a, rd_dm_b;
  logic [15:0]   dm_data_a, dm_data_b;
  logic          tx_start_a, tx_start_b;
  logic [7:0]    tx_data_a, tx_data_b;
  logic          tx_done_a, tx_done_b;
  logic          busy_a, busy_b, done_a, done_b;
  logic          resp_a = 1'b0, resp_b = 1'b0, spur_a = 1'b0;

  assign tx_done_a = resp_a | spur_a;
  assign tx_done_b = resp_b;

  dm_dump_ctrl #(.ADDR_W(AW), .RD_LATENCY(1), .SYNC_BYTE(8'hA5)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .base_addr(base), .word_count(count),
    .dm_addr(dm_addr_a), .rd_dm(rd_dm_a), .dm_data(dm_data_a),
    .tx_start(tx_start_a), .tx_data(tx_data_a), .tx_done(tx_done_a),
    .busy(busy_a), .done(done_a));

  dm_dump_ctrl #(.ADDR_W(AW), .RD_LATENCY(3), .SYNC_BYTE(8'hA5)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .base_addr(base), .word_count(count),
    .dm_addr(dm_addr_b), .rd_dm(rd_dm_b), .dm_data(dm_data_b),
    .tx_start(tx_start_b), .tx_data(tx_data_b), .tx_done(tx_done_b),
    .busy(busy_b), .done(done_b));

  // Memories drive garbage except in the single cycle the read data is valid.
  logic [15:0] mem_a [0:4095];
  logic [15:0] mem_b [0:4095];
  logic [15:0] s1_b, s2_b;
  always @(posedge clk) dm_data_a <= rd_dm_a ? mem_a[dm_addr_a] : 16'hDEAD;
  always @(posedge clk) begin
    s1_b      <= rd_dm_b ? mem_b[dm_addr_b] : 16'hDEAD;
    s2_b      <= s1_b;
    dm_data_b <= s2_b;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int tx_dly = 10;

  logic [7:0]    bytes_a[$], bytes_b[$];
  logic [AW-1:0] reads_a[$], reads_b[$];
  int done_cnt_a, done_cnt_b, viol_a, viol_b, cnt_a, cnt_b;
  int rd_cyc_a, hi_cyc_a, rd_cyc_b, hi_cyc_b;
  bit out_a, out_b;
  logic [7:0] hold_a, hold_b;

  always @(negedge clk) begin
    resp_a = 1'b0;
    if (reset) begin
      out_a = 1'b0; cnt_a = 0;
    end else begin
      if (rd_dm_a) begin
        reads_a.push_back(dm_addr_a);
        if (reads_a.size() == 1) rd_cyc_a = cyc;
      end
      if (done_a) done_cnt_a++;
      if (tx_start_a) begin
        if (out_a) viol_a++;
        out_a = 1'b1; cnt_a = tx_dly; hold_a = tx_data_a;
        bytes_a.push_back(tx_data_a);
        if (bytes_a.size() == 2) hi_cyc_a = cyc;
      end else if (out_a) begin
        if (tx_data_a !== hold_a) viol_a++;
        cnt_a--;
        if (cnt_a == 0) begin resp_a = 1'b1; out_a = 1'b0; end
      end
    end
  end

  always @(negedge clk) begin
    resp_b = 1'b0;
    if (reset) begin
      out_b = 1'b0; cnt_b = 0;
    end else begin
      if (rd_dm_b) begin
        reads_b.push_back(dm_addr_b);
        if (reads_b.size() == 1) rd_cyc_b = cyc;
      end
      if (done_b) done_cnt_b++;
      if (tx_start_b) begin
        if (out_b) viol_b++;
        out_b = 1'b1; cnt_b = tx_dly; hold_b = tx_data_b;
        bytes_b.push_back(tx_data_b);
        if (bytes_b.size() == 2) hi_cyc_b = cyc;
      end else if (out_b) begin
        if (tx_data_b !== hold_b) viol_b++;
        cnt_b--;
        if (cnt_b == 0) begin resp_b = 1'b1; out_b = 1'b0; end
      end
    end
  end

  task automatic clear_logs();
    bytes_a.delete(); reads_a.delete(); bytes_b.delete(); reads_b.delete();
    done_cnt_a = 0; done_cnt_b = 0; viol_a = 0; viol_b = 0;
    rd_cyc_a = -1; hi_cyc_a = -1; rd_cyc_b = -1; hi_cyc_b = -1;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done_a) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({dm_addr_a, rd_dm_a, tx_start_a, tx_data_a, busy_a, done_a} !== '0) begin
      errors++;
      $display("FAIL reset_a outputs got %h want 0",
               {dm_addr_a, rd_dm_a, tx_start_a, tx_data_a, busy_a, done_a});
    end
    checks++;
    if ({dm_addr_b, rd_dm_b, tx_start_b, tx_data_b, busy_b, done_b} !== '0) begin
      errors++;
      $display("FAIL reset_b outputs got %h want 0",
               {dm_addr_b, rd_dm_b, tx_start_b, tx_data_b, busy_b, done_b});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || tx_start_a !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy=%b tx_start=%b want 0 0", busy_a, tx_start_a);
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_basic();
    logic [7:0] exp[$];
    bit ok;
    exp = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    clear_logs();
    base = 12'h010; count = 13'd2;
    pulse_start_a();
    checks++;
    if (tx_start_a !== 1'b1 || tx_data_a !== 8'hA5 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL sync_timing tx_start=%b tx_data=%h busy=%b want 1 a5 1", tx_start_a, tx_data_a, busy_a);
    end
    wait_done_a(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout done=0 want 1"); end
    repeat (3) @(negedge clk);
    checks++;
    if (bytes_a.size() != exp.size()) begin
      errors++; $display("FAIL basic_len got %0d want %0d", bytes_a.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < bytes_a.size(); i++) begin
      checks++;
      if (bytes_a[i] !== exp[i]) begin
        errors++; $display("FAIL basic_byte%0d got %h want %h", i, bytes_a[i], exp[i]);
      end
    end
    checks++;
    if (reads_a.size() != 2 || reads_a[0] !== 12'h010 || reads_a[1] !== 12'h011) begin
      errors++; $display("FAIL basic_reads got n=%0d first=%h want n=2 010,011", reads_a.size(), reads_a[0]);
    end
    checks++;
    if (hi_cyc_a - rd_cyc_a !== 2) begin
      errors++; $display("FAIL basic_rd_to_hi got %0d want 2", hi_cyc_a - rd_cyc_a);
    end
    checks++;
    if (done_cnt_a !== 1 || viol_a !== 0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL basic_done done=%0d viol=%0d busy=%b want 1 0 0", done_cnt_a, viol_a, busy_a);
    end
    $display("frame basic: %0d bytes, %0d reads", bytes_a.size(), reads_a.size());
  endtask

  task automatic test_zero_count();
    bit ok;
    clear_logs();
    base = 12'h010; count = 13'd0;
    pulse_start_a();
    wait_done_a(2000, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || bytes_a.size() != 2) begin
      errors++; $display("FAIL zero_len ok=%b got %0d want 2", ok, bytes_a.size());
    end else begin
      checks++;
      if (bytes_a[0] !== 8'hA5 || bytes_a[1] !== 8'h00) begin
        errors++; $display("FAIL zero_bytes got %h %h want a5 00", bytes_a[0], bytes_a[1]);
      end
    end
    checks++;
    if (reads_a.size() != 0 || done_cnt_a !== 1) begin
      errors++; $display("FAIL zero_reads reads=%0d done=%0d want 0 1", reads_a.size(), done_cnt_a);
    end
    $display("frame zero: %0d bytes", bytes_a.size());
  endtask

  task automatic test_wrap();
    logic [7:0] exp[$];
    bit ok;
    exp = '{8'hA5, 8'h5A, 8'h01, 8'h7E, 8'h81, 8'hA4};
    clear_logs();
    base = 12'hFFF; count = 13'd2;
    pulse_start_a();
    wait_done_a(2000, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || reads_a.size() != 2) begin
      errors++; $display("FAIL wrap_reads ok=%b got %0d want 2", ok, reads_a.size());
    end else begin
      checks++;
      if (reads_a[0] !== 12'hFFF || reads_a[1] !== 12'h000) begin
        errors++; $display("FAIL wrap_addr got %h %h want fff 000", reads_a[0], reads_a[1]);
      end
    end
    checks++;
    if (bytes_a.size() != exp.size()) begin
      errors++; $display("FAIL wrap_len got %0d want %0d", bytes_a.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < bytes_a.size(); i++) begin
      checks++;
      if (bytes_a[i] !== exp[i]) begin
        errors++; $display("FAIL wrap_byte%0d got %h want %h", i, bytes_a[i], exp[i]);
      end
    end
    $display("frame wrap: %0d bytes, %0d reads", bytes_a.size(), reads_a.size());
  endtask

  task automatic test_busy_ignore();
    logic [7:0] exp[$];
    bit ok;
    exp = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    clear_logs();
    base = 12'h010; count = 13'd2;
    pulse_start_a();
    base = 12'h020; count = 13'd5;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      start_a = (i == 20 || i == 45);
      spur_a  = tx_start_a && (tx_data_a == 8'h34);
      if (done_a) begin ok = 1'b1; break; end
    end
    start_a = 1'b0; spur_a = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL busy_timeout done=0 want 1"); end
    checks++;
    if (bytes_a.size() != exp.size()) begin
      errors++; $display("FAIL busy_len got %0d want %0d", bytes_a.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < bytes_a.size(); i++) begin
      checks++;
      if (bytes_a[i] !== exp[i]) begin
        errors++; $display("FAIL busy_byte%0d got %h want %h", i, bytes_a[i], exp[i]);
      end
    end
    checks++;
    if (reads_a.size() != 2 || done_cnt_a !== 1 || viol_a !== 0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL busy_misc reads=%0d done=%0d viol=%0d busy=%b want 2 1 0 0",
               reads_a.size(), done_cnt_a, viol_a, busy_a);
    end
    $display("frame busy_ignore: %0d bytes", bytes_a.size());
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp[$];
    bit found, ok;
    exp = '{8'hA5, 8'hAB, 8'hCD, 8'h66};
    clear_logs();
    base = 12'h010; count = 13'd2;
    pulse_start_a();
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx_start_a && tx_data_a == 8'h34) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midreset_third_byte seen=0 want 1"); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({dm_addr_a, rd_dm_a, tx_start_a, tx_data_a, busy_a, done_a} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got %h want 0",
               {dm_addr_a, rd_dm_a, tx_start_a, tx_data_a, busy_a, done_a});
    end
    @(negedge clk);
    reset = 1'b0;
    clear_logs();
    repeat (40) @(negedge clk);
    checks++;
    if (bytes_a.size() != 0 || done_cnt_a !== 0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL midreset_quiet bytes=%0d done=%0d busy=%b want 0 0 0", bytes_a.size(), done_cnt_a, busy_a);
    end
    base = 12'h011; count = 13'd1;
    pulse_start_a();
    wait_done_a(2000, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || bytes_a.size() != exp.size()) begin
      errors++; $display("FAIL midreset_len ok=%b got %0d want %0d", ok, bytes_a.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < bytes_a.size(); i++) begin
      checks++;
      if (bytes_a[i] !== exp[i]) begin
        errors++; $display("FAIL midreset_byte%0d got %h want %h", i, bytes_a[i], exp[i]);
      end
    end
    $display("frame after reset: %0d bytes", bytes_a.size());
  endtask

  task automatic test_start_after_fin();
    bit ok;
    clear_logs();
    base = 12'h000; count = 13'd0;
    pulse_start_a();
    wait_done_a(2000, ok);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || busy_a !== 1'b0 || bytes_a.size() != 2) begin
      errors++;
      $display("FAIL start_in_fin ok=%b busy=%b bytes=%0d want 1 0 2", ok, busy_a, bytes_a.size());
    end
    pulse_start_a();
    wait_done_a(2000, ok);
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    checks++;
    if (!ok || tx_start_a !== 1'b1 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL start_after_fin ok=%b tx_start=%b busy=%b want 1 1 1", ok, tx_start_a, busy_a);
    end
    wait_done_a(2000, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || done_cnt_a !== 3) begin
      errors++; $display("FAIL back_to_back_done ok=%b got %0d want 3", ok, done_cnt_a);
    end
    $display("frames back_to_back: %0d done pulses", done_cnt_a);
  endtask

  task automatic test_saturate();
    bit ok;
    clear_logs();
    tx_dly = 1;
    base = 12'h100; count = 13'h1FFF;
    pulse_start_a();
    wait_done_a(60000, ok);
    repeat (3) @(negedge clk);
    tx_dly = 10;
    checks++;
    if (!ok || bytes_a.size() != 8194 || reads_a.size() != 4096) begin
      errors++;
      $display("FAIL saturate_len ok=%b bytes=%0d reads=%0d want 1 8194 4096", ok, bytes_a.size(), reads_a.size());
    end else begin
      checks++;
      if (reads_a[3840] !== 12'h000 || reads_a[4095] !== 12'h0FF || viol_a !== 0) begin
        errors++;
        $display("FAIL saturate_addr got %h %h viol=%0d want 000 0ff 0", reads_a[3840], reads_a[4095], viol_a);
      end
    end
    $display("frame saturate: %0d bytes", bytes_a.size());
  endtask

  task automatic test_latency3();
    logic [7:0] exp[$];
    bit ok;
    exp = '{8'hA5, 8'h00, 8'hFF, 8'hFF};
    clear_logs();
    base = 12'h005; count = 13'd1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done_b) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || bytes_b.size() != exp.size()) begin
      errors++; $display("FAIL lat3_len ok=%b got %0d want %0d", ok, bytes_b.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < bytes_b.size(); i++) begin
      checks++;
      if (bytes_b[i] !== exp[i]) begin
        errors++; $display("FAIL lat3_byte%0d got %h want %h", i, bytes_b[i], exp[i]);
      end
    end
    checks++;
    if (hi_cyc_b - rd_cyc_b !== 4 || reads_b.size() != 1 || done_cnt_b !== 1) begin
      errors++;
      $display("FAIL lat3_timing rd_to_hi=%0d reads=%0d done=%0d want 4 1 1",
               hi_cyc_b - rd_cyc_b, reads_b.size(), done_cnt_b);
    end
    $display("frame latency3: %0d bytes", bytes_b.size());
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_a[i] = 16'h0000;
      mem_b[i] = 16'h0000;
    end
    mem_a[12'h010] = 16'h1234;
    mem_a[12'h011] = 16'hABCD;
    mem_a[12'hFFF] = 16'h5A01;
    mem_a[12'h000] = 16'h7E81;
    mem_b[12'h005] = 16'h00FF;
    clear_logs();
    test_reset();
    test_basic();
    test_zero_count();
    test_wrap();
    test_busy_ignore();
    test_reset_mid();
    test_start_after_fin();
    test_saturate();
    test_latency3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
